arduino_link_rx: RTL and testbench

Serial receiver for the Arduino link: the FPGA-to-Arduino direction is a single sensor flag, and this block is the Arduino-to-FPGA direction. It receives 8N1 asynchronous UART bytes on one pin, checks framing, and presents each good byte as a data word with a one-cycle valid strobe. It also shows the last good byte as two hex digits on the board's seven-segment pair and drives status LEDs. It sits beside the sensor/display logic and feeds board-level outputs directly.

---
 rtl/arduino_link_rx_if.sv | 36 +++
 rtl/arduino_link_rx.sv | 230 +++++++++++++++++++++++
 tb/tb_arduino_link_rx.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/arduino_link_rx_if.sv
// arduino_link_rx_if
//   Signal bundle between the Arduino serial receiver and the board-level logic.
//   slave  : receiver side (takes rx, drives the byte, strobes, display and LEDs)
//   master : board / test side (drives rx, observes everything else)
//   Signals:
//     rx         serial line from the Arduino, idle high
//     data       last good received byte
//     valid      one-cycle strobe when data updates
//     frame_err  one-cycle strobe when a frame is discarded for a bad stop bit
//     parity_err one-cycle strobe on even-parity mismatch (parity build only)
//     busy       high while a frame is being received
//     seg, seg2  active-low {g,f,e,d,c,b,a} glyphs for data[7:4] and data[3:0]
//     led1       activity LED, lit for four bit-times after each valid
//     led2       sticky error LED, cleared by the next valid
interface arduino_link_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;
    logic [6:0] seg;
    logic [6:0] seg2;
    logic       led1;
    logic       led2;

    modport slave (
        input  rx,
        output data, valid, frame_err, parity_err, busy, seg, seg2, led1, led2
    );

    modport master (
        output rx,
        input  data, valid, frame_err, parity_err, busy, seg, seg2, led1, led2
    );
endinterface

// File: rtl/arduino_link_rx.sv
// arduino_link_rx
//   UART receiver for the Arduino-to-FPGA direction. Receives 8N1 bytes
//   (8E1 when ARDUINO_RX_PARITY_EN is defined), checks framing, strobes each
//   good byte out with a one-cycle valid, shows it on the seven-segment pair
//   and drives an activity LED and a sticky error LED.
//   Parameters: CLK_HZ system clock in Hz, BAUD line rate. DIV = CLK_HZ/BAUD
//   must be at least 8.
//   Ports: clk, reset (async, active high), link (arduino_link_rx_if.slave).
//   Build option: ARDUINO_RX_PARITY_EN adds an even-parity bit before the
//   stop bit; without it parity_err is held at 0.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   IDLE      | line idle, waiting for a falling edge on rxs
//   START     | half a bit period in; confirm the start bit is still low
//   DATA      | sampling 8 data bits, LSB first, one per bit period
//   PARITY    | sampling the even-parity bit (parity build only)
//   STOP      | sampling the stop bit; commit or report the error
//   WAIT_HIGH | line held low after a bad stop bit; wait for it to release
module arduino_link_rx #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 9600
) (
    input logic               clk,
    input logic               reset,
    arduino_link_rx_if.slave  link
);
    localparam int DIV     = CLK_HZ / BAUD;
    localparam int HALF    = DIV / 2;
    localparam int CW      = $clog2(DIV);
    localparam int LED_CNT = DIV * 4;
    localparam int LW      = $clog2(LED_CNT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t          state_q;
    logic            rx_meta_q;
    logic            rxs_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic [7:0]      data_q;
    logic            valid_q;
    logic            frame_err_q;
    logic            parity_err_q;
    logic            busy_q;
    logic [6:0]      seg_q;
    logic [6:0]      seg2_q;
    logic [LW-1:0]   led_cnt_q;
    logic            led2_q;
`ifdef ARDUINO_RX_PARITY_EN
    logic            par_ok_q;
`endif

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 7'b1000000;
            4'h1: hex_glyph = 7'b1111001;
            4'h2: hex_glyph = 7'b0100100;
            4'h3: hex_glyph = 7'b0110000;
            4'h4: hex_glyph = 7'b0011001;
            4'h5: hex_glyph = 7'b0010010;
            4'h6: hex_glyph = 7'b0000010;
            4'h7: hex_glyph = 7'b1111000;
            4'h8: hex_glyph = 7'b0000000;
            4'h9: hex_glyph = 7'b0010000;
            4'hA: hex_glyph = 7'b0001000;
            4'hB: hex_glyph = 7'b0000011;
            4'hC: hex_glyph = 7'b1000110;
            4'hD: hex_glyph = 7'b0100001;
            4'hE: hex_glyph = 7'b0000110;
            default: hex_glyph = 7'b0001110;
        endcase
    endfunction

    // Synchronizer resets to the idle-high level so reset release never
    // looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= link.rx;
            rxs_q     <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            busy_q       <= 1'b0;
            seg_q        <= 7'b1000000;
            seg2_q       <= 7'b1000000;
            led_cnt_q    <= '0;
            led2_q       <= 1'b0;
`ifdef ARDUINO_RX_PARITY_EN
            par_ok_q     <= 1'b0;
`endif
        end else begin
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            if (led_cnt_q != '0) begin
                led_cnt_q <= led_cnt_q - LW'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (!rxs_q) begin
                        cnt_q   <= CW'(HALF - 1);
                        busy_q  <= 1'b1;
                        state_q <= S_START;
                    end
                end

                S_START: begin
                    if (cnt_q == '0) begin
                        if (rxs_q) begin
                            // Line went back high: a glitch, not a start bit.
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q     <= CW'(DIV - 1);
                            bit_idx_q <= '0;
                            state_q   <= S_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end

                S_DATA: begin
                    if (cnt_q == '0) begin
                        shift_q <= {rxs_q, shift_q[7:1]};
                        cnt_q   <= CW'(DIV - 1);
                        if (bit_idx_q == 3'd7) begin
`ifdef ARDUINO_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end

`ifdef ARDUINO_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == '0) begin
                        // Even parity: the parity bit equals the XOR of the data.
                        par_ok_q <= (rxs_q == ^shift_q);
                        cnt_q    <= CW'(DIV - 1);
                        state_q  <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
`endif

                S_STOP: begin
                    if (cnt_q == '0) begin
                        busy_q <= 1'b0;
                        if (!rxs_q) begin
                            // A bad stop bit outranks a parity mismatch.
                            frame_err_q <= 1'b1;
                            led2_q      <= 1'b1;
                            state_q     <= S_WAIT_HIGH;
`ifdef ARDUINO_RX_PARITY_EN
                        end else if (!par_ok_q) begin
                            parity_err_q <= 1'b1;
                            led2_q       <= 1'b1;
                            state_q      <= S_IDLE;
`endif
                        end else begin
                            data_q    <= shift_q;
                            valid_q   <= 1'b1;
                            seg_q     <= hex_glyph(shift_q[7:4]);
                            seg2_q    <= hex_glyph(shift_q[3:0]);
                            led2_q    <= 1'b0;
                            led_cnt_q <= LW'(LED_CNT);
                            state_q   <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end

                S_WAIT_HIGH: begin
                    // A break or stuck-low line must not start a new frame.
                    if (rxs_q) begin
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign link.data       = data_q;
    assign link.valid      = valid_q;
    assign link.frame_err  = frame_err_q;
    assign link.parity_err = parity_err_q;
    assign link.busy       = busy_q;
    assign link.seg        = seg_q;
    assign link.seg2       = seg2_q;
    assign link.led1       = (led_cnt_q != '0);
    assign link.led2       = led2_q;

endmodule

// File: tb/tb_arduino_link_rx.sv
// tb_arduino_link_rx
//   Drives UART frames into arduino_link_rx, pushes the expected outcome of
//   each frame (kind, data on the bus, cycle of the strobe) into a queue, and
//   a monitor pops and compares whenever any strobe appears. Build with or
//   without ARDUINO_RX_PARITY_EN to match the RTL.
module tb_arduino_link_rx;
    localparam int CLK_HZ = 160;
    localparam int BAUD   = 10;
    localparam int DIV    = CLK_HZ / BAUD;
`ifdef ARDUINO_RX_PARITY_EN
    localparam int  NBITS = 11;
    localparam bit  PAR   = 1'b1;
`else
    localparam int  NBITS = 10;
    localparam bit  PAR   = 1'b0;
`endif
    // Strobe visible after this many edges from the edge preceding the rx fall:
    // 2 synchronizer + 1 IDLE detect + half bit + (stop index) full bits.
    localparam int LAT = 3 + DIV / 2 + (NBITS - 1) * DIV;

    localparam int K_VALID = 0;
    localparam int K_FERR  = 1;
    localparam int K_PERR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] d;
        int         at;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    arduino_link_rx_if link();

    arduino_link_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk   (clk),
        .reset (reset),
        .link  (link)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    exp_t       sb [$];
    logic [7:0] last_good = 8'h00;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    exp_t mon_e;
    int   mon_kind;
    int   mon_np;
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            mon_np = int'(link.valid) + int'(link.frame_err) + int'(link.parity_err);
            if (mon_np > 0) begin
                check("one_strobe", 32'(mon_np), 32'd1);
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_strobe: got valid=%0b ferr=%0b perr=%0b expected none (cycle %0d)",
                             link.valid, link.frame_err, link.parity_err, cyc);
                end else begin
                    mon_e    = sb.pop_front();
                    mon_kind = link.valid ? K_VALID : (link.frame_err ? K_FERR : K_PERR);
                    check("strobe_kind", 32'(mon_kind), 32'(mon_e.kind));
                    check("strobe_cycle", 32'(cyc), 32'(mon_e.at));
                    check("data", 32'(link.data), 32'(mon_e.d));
                    check("seg", 32'(link.seg), 32'(glyph[mon_e.d[7:4]]));
                    check("seg2", 32'(link.seg2), 32'(glyph[mon_e.d[3:0]]));
                    check("led2", 32'(link.led2), 32'(mon_e.kind != K_VALID));
                    check("busy_after_stop", 32'(link.busy), 32'd0);
                end
            end
        end
    end

    // led1 must stay lit for exactly four bit times after each valid.
    int led_run = 0;
    always @(negedge clk) begin
        if (link.led1 === 1'b1) begin
            led_run++;
        end else if (led_run > 0) begin
            check("led1_length", 32'(led_run), 32'(DIV * 4));
            led_run = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        link.rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called aligned 1 time unit after a rising edge; returns aligned the same way.
    task automatic send_frame(input logic [7:0] b, input bit bad_stop, input bit bad_par,
                              input int hold_bits);
        logic [10:0] fr;
        exp_t        e;
        bit          perr;
        perr   = bad_par && PAR;
        fr     = '1;
        fr[0]  = 1'b0;
        fr[8:1] = b;
        if (PAR) begin
            fr[9]  = 1'(($countones(b) % 2) == 1) ^ perr;
            fr[10] = !bad_stop;
        end else begin
            fr[9]  = !bad_stop;
        end
        e.at = cyc + LAT;
        if (bad_stop) begin
            e.kind = K_FERR;
            e.d    = last_good;
        end else if (perr) begin
            e.kind = K_PERR;
            e.d    = last_good;
        end else begin
            e.kind    = K_VALID;
            e.d       = b;
            last_good = b;
        end
        sb.push_back(e);
        for (int i = 0; i < NBITS; i++) begin
            link.rx = fr[i];
            repeat (DIV) @(posedge clk);
            #1;
            if (i == 2) check("busy_mid_frame", 32'(link.busy), 32'd1);
        end
        if (bad_stop) begin
            repeat (hold_bits * DIV) @(posedge clk);
            #1;
            link.rx = 1'b1;
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    task automatic glitch(input int len);
        link.rx = 1'b0;
        repeat (len) @(posedge clk);
        #1;
        idle(DIV + 4);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data"}, 32'(link.data), 32'h00);
        check({tag, "_valid"}, 32'(link.valid), 32'd0);
        check({tag, "_frame_err"}, 32'(link.frame_err), 32'd0);
        check({tag, "_parity_err"}, 32'(link.parity_err), 32'd0);
        check({tag, "_busy"}, 32'(link.busy), 32'd0);
        check({tag, "_seg"}, 32'(link.seg), 32'(7'b1000000));
        check({tag, "_seg2"}, 32'(link.seg2), 32'(7'b1000000));
        check({tag, "_led1"}, 32'(link.led1), 32'd0);
        check({tag, "_led2"}, 32'(link.led2), 32'd0);
    endtask

    initial begin
        bit         bs;
        bit         bp;
        logic [7:0] rb;
        reset   = 1'b1;
        link.rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b0;
        idle(10);
        check_reset_values("after_reset");

        send_frame(8'hA5, 1'b0, 1'b0, 0);
        idle(80);

        send_frame(8'h3C, 1'b1, 1'b0, 50);
        check("break_led2", 32'(link.led2), 32'd1);
        check("break_data", 32'(link.data), 32'(last_good));
        idle(20);

        glitch(5);
        check("glitch_busy", 32'(link.busy), 32'd0);

        send_frame(8'h01, 1'b0, 1'b0, 0);
        send_frame(8'hFE, 1'b0, 1'b0, 0);
        idle(20);
        check("b2b_data", 32'(link.data), 32'hFE);
        check("b2b_led2", 32'(link.led2), 32'd0);

        if (PAR) begin
            send_frame(8'h07, 1'b0, 1'b1, 0);
            idle(20);
            check("par_led2", 32'(link.led2), 32'd1);
            send_frame(8'h07, 1'b0, 1'b0, 0);
            idle(20);
            check("par_data", 32'(link.data), 32'h07);
        end

        for (int n = 0; n < 30; n++) begin
            rb = 8'($urandom_range(0, 255));
            bs = ($urandom_range(0, 5) == 0);
            bp = ($urandom_range(0, 4) == 0);
            send_frame(rb, bs, bp, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 7) == 0) glitch(int'($urandom_range(1, 5)));
            idle(int'($urandom_range(0, 20)));
        end

        // Abort mid-frame: no strobe, everything back to reset values.
        idle(100);
        link.rx = 1'b0;
        repeat (3 * DIV) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_reset_values("abort");
        link.rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b0;
        last_good = 8'h00;
        idle(DIV * 12);
        check_reset_values("abort_quiet");

        send_frame(8'h5A, 1'b0, 1'b0, 0);
        idle(10);

        for (int w = 0; w < 2000 && sb.size() != 0; w++) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        idle(80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
